// File: rtl/dispatch_alu.sv
// 2-wide ALU dispatch: busy table, source-ready calc, one-entry output register; 1 cycle fire->enq_req, holds and wakes while !iq_ready.
// Layouts: uop = {payload, dstwe, dstPAddr, op1PAddr, op0PAddr}; meta = {prs2_rdy, prs1_rdy, uop}; wake port k = {wen_k, wb_numk_i}. Option: DISPATCH_PERF_CNT_EN.
module dispatch_alu #(
  parameter int NUM_PRF = 64,
  parameter int PRF_W   = 6,
  parameter int UOP_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid_0,
  input  logic                     in_valid_1,
  input  logic [UOP_W-1:0]         in_uop_0,
  input  logic [UOP_W-1:0]         in_uop_1,
  output logic                     in_ready,
  input  logic [4*(PRF_W+1)-1:0]   wake_Info,
  input  logic                     iq_ready,
  output logic                     enq_req_0,
  output logic                     enq_req_1,
  output logic [UOP_W+1:0]         inst_Ops_0,
  output logic [UOP_W+1:0]         inst_Ops_1
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              disp_cnt
`endif
);

  logic [NUM_PRF-1:0] busy_q, busy_d, wake_vec;
  logic               out_valid_0, out_valid_1;
  logic [UOP_W-1:0]   out_uop_0, out_uop_1;
  logic               out_r1_0, out_r2_0, out_r1_1, out_r2_1;

  logic               fire, ld_v0, ld_v1, dep_s1, dep_s2;
  logic [UOP_W-1:0]   ld_u0;
  logic               r1_0, r2_0, r1_1, r2_1;

  assign in_ready = !(out_valid_0 | out_valid_1) || iq_ready;
  assign fire     = in_ready && (in_valid_0 | in_valid_1);
  assign ld_v0    = in_valid_0 | in_valid_1;
  assign ld_v1    = in_valid_0 & in_valid_1;
  assign ld_u0    = in_valid_0 ? in_uop_0 : in_uop_1;

  always_comb begin
    wake_vec = '0;
    for (int k = 0; k < 4; k++) begin
      if (wake_Info[k*(PRF_W+1)+PRF_W])
        wake_vec[wake_Info[k*(PRF_W+1) +: PRF_W]] = 1'b1;
    end
  end

  // Lane 1 is only a real younger uop when both lanes are valid; otherwise it was compacted into lane 0.
  assign dep_s1 = ld_v1 && in_uop_0[3*PRF_W] && (in_uop_0[3*PRF_W-1:2*PRF_W] != '0) &&
                  (in_uop_1[PRF_W-1:0] == in_uop_0[3*PRF_W-1:2*PRF_W]);
  assign dep_s2 = ld_v1 && in_uop_0[3*PRF_W] && (in_uop_0[3*PRF_W-1:2*PRF_W] != '0) &&
                  (in_uop_1[2*PRF_W-1:PRF_W] == in_uop_0[3*PRF_W-1:2*PRF_W]);

  assign r1_0 = (ld_u0[PRF_W-1:0] == '0) || !busy_q[ld_u0[PRF_W-1:0]] ||
                wake_vec[ld_u0[PRF_W-1:0]];
  assign r2_0 = (ld_u0[2*PRF_W-1:PRF_W] == '0) || !busy_q[ld_u0[2*PRF_W-1:PRF_W]] ||
                wake_vec[ld_u0[2*PRF_W-1:PRF_W]];
  assign r1_1 = !dep_s1 && ((in_uop_1[PRF_W-1:0] == '0) || !busy_q[in_uop_1[PRF_W-1:0]] ||
                wake_vec[in_uop_1[PRF_W-1:0]]);
  assign r2_1 = !dep_s2 && ((in_uop_1[2*PRF_W-1:PRF_W] == '0) ||
                !busy_q[in_uop_1[2*PRF_W-1:PRF_W]] || wake_vec[in_uop_1[2*PRF_W-1:PRF_W]]);

  // Clears first so a same-cycle set on the same PRF wins.
  always_comb begin
    busy_d = busy_q & ~wake_vec;
    if (fire) begin
      if (in_valid_0 && in_uop_0[3*PRF_W]) busy_d[in_uop_0[3*PRF_W-1:2*PRF_W]] = 1'b1;
      if (in_valid_1 && in_uop_1[3*PRF_W]) busy_d[in_uop_1[3*PRF_W-1:2*PRF_W]] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy_q      <= '0;
      out_valid_0 <= 1'b0;
      out_valid_1 <= 1'b0;
      out_uop_0   <= '0;
      out_uop_1   <= '0;
      out_r1_0    <= 1'b0;
      out_r2_0    <= 1'b0;
      out_r1_1    <= 1'b0;
      out_r2_1    <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (fire) begin
        out_valid_0 <= ld_v0;
        out_valid_1 <= ld_v1;
        out_uop_0   <= ld_u0;
        out_uop_1   <= in_uop_1;
        out_r1_0    <= r1_0;
        out_r2_0    <= r2_0;
        out_r1_1    <= r1_1;
        out_r2_1    <= r2_1;
      end else if (iq_ready) begin
        out_valid_0 <= 1'b0;
        out_valid_1 <= 1'b0;
      end else begin
        out_r1_0 <= out_r1_0 | wake_vec[out_uop_0[PRF_W-1:0]];
        out_r2_0 <= out_r2_0 | wake_vec[out_uop_0[2*PRF_W-1:PRF_W]];
        out_r1_1 <= out_r1_1 | wake_vec[out_uop_1[PRF_W-1:0]];
        out_r2_1 <= out_r2_1 | wake_vec[out_uop_1[2*PRF_W-1:PRF_W]];
      end
    end
  end

  assign enq_req_0  = out_valid_0 && iq_ready;
  assign enq_req_1  = out_valid_1 && iq_ready;
  assign inst_Ops_0 = {out_r2_0, out_r1_0, out_uop_0};
  assign inst_Ops_1 = {out_r2_1, out_r1_1, out_uop_1};

`ifdef DISPATCH_PERF_CNT_EN
  // Counters survive flush on purpose; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      disp_cnt  <= '0;
    end else begin
      if ((out_valid_0 | out_valid_1) && !iq_ready) stall_cnt <= stall_cnt + 32'd1;
      disp_cnt <= disp_cnt + {31'd0, enq_req_0} + {31'd0, enq_req_1};
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_alu.sv
// Directed bench for dispatch_alu: hand-computed vectors covering readiness, compaction, hold/wake, busy set/clear and flush.
module tb_dispatch_alu;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid_0, in_valid_1, in_ready, iq_ready;
  logic [31:0] in_uop_0, in_uop_1;
  logic [27:0] wake_Info;
  logic        enq_req_0, enq_req_1;
  logic [33:0] inst_Ops_0, inst_Ops_1;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] stall_cnt, disp_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dispatch_alu dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid_0(in_valid_0), .in_valid_1(in_valid_1),
    .in_uop_0(in_uop_0), .in_uop_1(in_uop_1),
    .in_ready(in_ready), .wake_Info(wake_Info), .iq_ready(iq_ready),
    .enq_req_0(enq_req_0), .enq_req_1(enq_req_1),
    .inst_Ops_0(inst_Ops_0), .inst_Ops_1(inst_Ops_1)
`ifdef DISPATCH_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .disp_cnt(disp_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op0, input int op1, input int dst,
                                     input bit we, input int tag);
    logic [12:0] t;
    logic [5:0]  a, b, d;
    t = 13'(tag); a = 6'(op0); b = 6'(op1); d = 6'(dst);
    return {t, we, d, b, a};
  endfunction

  function automatic logic [33:0] meta(input bit r2, input bit r1, input logic [31:0] u);
    return {r2, r1, u};
  endfunction

  task automatic set_wake(input int k, input int num);
    logic [5:0] n;
    n = 6'(num);
    wake_Info[k*7 +: 7] = {1'b1, n};
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] u_a, u_b;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid_0 = 1'b0; in_valid_1 = 1'b0;
    in_uop_0 = '0; in_uop_1 = '0; wake_Info = '0; iq_ready = 1'b1;
    step; step;
    rst = 1'b0;
    #1;
    check("rst_enq0", {63'd0, enq_req_0}, 64'd0);
    check("rst_enq1", {63'd0, enq_req_1}, 64'd0);
    check("rst_ops0", {30'd0, inst_Ops_0}, 64'd0);
    check("rst_ops1", {30'd0, inst_Ops_1}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // single lane 0 uop, all sources ready
    u_a = mk(5, 0, 9, 1'b1, 1);
    in_valid_0 = 1'b1; in_uop_0 = u_a;
    step;
    in_valid_0 = 1'b0;
    check("single_enq0", {63'd0, enq_req_0}, 64'd1);
    check("single_enq1", {63'd0, enq_req_1}, 64'd0);
    check("single_ops0", {30'd0, inst_Ops_0}, {30'd0, meta(1, 1, u_a)});

    // pair: lane 0 reads busy p9, lane 1 depends on lane 0 dst p10, lane 1 writes p0
    u_a = mk(9, 0, 10, 1'b1, 2);
    u_b = mk(10, 0, 0, 1'b1, 3);
    in_valid_0 = 1'b1; in_valid_1 = 1'b1; in_uop_0 = u_a; in_uop_1 = u_b;
    step;
    in_valid_0 = 1'b0; in_valid_1 = 1'b0;
    check("pair_enq0", {63'd0, enq_req_0}, 64'd1);
    check("pair_enq1", {63'd0, enq_req_1}, 64'd1);
    check("pair_ops0", {30'd0, inst_Ops_0}, {30'd0, meta(1, 0, u_a)});
    check("pair_ops1", {30'd0, inst_Ops_1}, {30'd0, meta(1, 0, u_b)});
    check("busy0_zero", {63'd0, dut.busy_q[0]}, 64'd0);

    // hold three cycles, p10 woken in the second
    iq_ready = 1'b0;
    #1;
    check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    check("hold_enq0", {63'd0, enq_req_0}, 64'd0);
    step;
    check("hold1_ops1", {30'd0, inst_Ops_1}, {30'd0, meta(1, 0, u_b)});
    set_wake(2, 10);
    step;
    wake_Info = '0;
    check("hold2_ops1", {30'd0, inst_Ops_1}, {30'd0, meta(1, 1, u_b)});
    check("hold2_ops0", {30'd0, inst_Ops_0}, {30'd0, meta(1, 0, u_a)});
    check("hold2_in_ready", {63'd0, in_ready}, 64'd0);
    step;
    iq_ready = 1'b1;
    #1;
    check("release_enq0", {63'd0, enq_req_0}, 64'd1);
    check("release_enq1", {63'd0, enq_req_1}, 64'd1);
    check("release_ops1", {30'd0, inst_Ops_1}, {30'd0, meta(1, 1, u_b)});
    step;
    check("drained_enq0", {63'd0, enq_req_0}, 64'd0);

    // set and clear of p12 in the same cycle: set wins
    in_valid_0 = 1'b1; in_uop_0 = mk(0, 0, 12, 1'b1, 4);
    set_wake(0, 12);
    step;
    wake_Info = '0;
    u_a = mk(12, 0, 0, 1'b0, 5);
    in_uop_0 = u_a;
    step;
    in_valid_0 = 1'b0;
    check("setwins_ops0", {30'd0, inst_Ops_0}, {30'd0, meta(1, 0, u_a)});

    // lane 1 alone is compacted into output lane 0; junk on lane 0 must not mark busy
    u_b = mk(0, 7, 0, 1'b0, 6);
    in_valid_1 = 1'b1; in_uop_1 = u_b; in_uop_0 = mk(1, 1, 20, 1'b1, 7);
    step;
    in_valid_1 = 1'b0;
    check("compact_enq0", {63'd0, enq_req_0}, 64'd1);
    check("compact_enq1", {63'd0, enq_req_1}, 64'd0);
    check("compact_ops0", {30'd0, inst_Ops_0}, {30'd0, meta(1, 1, u_b)});
    u_a = mk(20, 0, 0, 1'b0, 8);
    in_valid_0 = 1'b1; in_uop_0 = u_a;
    step;
    check("no_busy_invalid", {30'd0, inst_Ops_0}, {30'd0, meta(1, 1, u_a)});

    // flush while holding a uop that reads busy p9
    u_a = mk(9, 0, 0, 1'b0, 9);
    in_uop_0 = u_a;
    step;
    in_valid_0 = 1'b0;
    check("preflush_ops0", {30'd0, inst_Ops_0}, {30'd0, meta(1, 0, u_a)});
    iq_ready = 1'b0;
    step;
    check("preflush_enq0", {63'd0, enq_req_0}, 64'd0);
    flush = 1'b1;
    step;
    flush = 1'b0; iq_ready = 1'b1;
    #1;
    check("flush_enq0", {63'd0, enq_req_0}, 64'd0);
    check("flush_ops0", {30'd0, inst_Ops_0}, 64'd0);
    u_a = mk(9, 0, 0, 1'b0, 10);
    in_valid_0 = 1'b1; in_uop_0 = u_a;
    step;
    in_valid_0 = 1'b0;
    check("postflush_ops0", {30'd0, inst_Ops_0}, {30'd0, meta(1, 1, u_a)});
    check("postflush_enq0", {63'd0, enq_req_0}, 64'd1);
    step;

`ifdef DISPATCH_PERF_CNT_EN
    rst = 1'b1;
    step;
    rst = 1'b0;
    #1;
    check("perf_rst_stall", {32'd0, stall_cnt}, 64'd0);
    check("perf_rst_disp", {32'd0, disp_cnt}, 64'd0);
    in_valid_0 = 1'b1; in_valid_1 = 1'b1;
    in_uop_0 = mk(0, 0, 0, 1'b0, 11); in_uop_1 = mk(0, 0, 0, 1'b0, 12);
    step;
    in_valid_0 = 1'b0; in_valid_1 = 1'b0; iq_ready = 1'b0;
    for (int i = 0; i < 4; i++) step;
    iq_ready = 1'b1;
    step;
    check("perf_stall", {32'd0, stall_cnt}, 64'd4);
    check("perf_disp", {32'd0, disp_cnt}, 64'd2);
    flush = 1'b1;
    step;
    flush = 1'b0;
    #1;
    check("perf_flush_stall", {32'd0, stall_cnt}, 64'd4);
    check("perf_flush_disp", {32'd0, disp_cnt}, 64'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
